// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory unit: fun3 encodings, FSM states,
// and the store byte-enable / misalignment helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  // Lane mask for a store; undefined sizes write nothing.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      F3_B:    be = 4'b0001 << addr_lo;
      F3_H:    be = 4'b0011 << {addr_lo[1], 1'b0};
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Contents are never reset.
module dmem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [3:0]       i_we,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_we[l]) r_mem[i_idx][8*l +: 8] <= i_wdata[8*l +: 8];
    end
    // Read data holds until the next accepted load.
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_unit.sv
// Load/store responder for the RV32IM core: one-cycle stores, fixed-latency loads.
// Optional feature macro: DMEM_MISALIGN_EN (adds misalign_o, blocks misaligned accesses).
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned LOAD_LATENCY = 2,
  parameter int unsigned FUNCTION3    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Load,
  input  logic                  Store,
  input  logic [FUNCTION3-1:0]  fun3,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  DM_valid,
  output logic                  busy_o
`ifdef DMEM_MISALIGN_EN
  ,
  output logic                  misalign_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LOAD_LATENCY > 2) ? $clog2(LOAD_LATENCY) : 1;

  dmem_state_t r_state_q, r_state_d;
  logic [CNT_W-1:0] r_count_q, r_count_d;
  logic [1:0] r_lo_q;
  logic [2:0] r_f3_q;
  logic r_mis_q;

  logic [2:0] w_f3;
  logic [1:0] w_lo;
  logic w_store, w_accept, w_mis_ld, w_mis_st;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_rd, w_ext;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [CNT_W-1:0] w_count_inc;
  logic w_unused;

  assign w_f3     = fun3[2:0];
  assign w_lo     = addr_i[1:0];
  assign w_store  = !rst && (r_state_q == IDLE) && Store;
  assign w_accept = !rst && (r_state_q == IDLE) && Load && !Store;
  assign w_unused = ^{addr_i[ADDR_WIDTH-1:IDX_W+2]};

`ifdef DMEM_MISALIGN_EN
  assign w_mis_ld   = misaligned(w_f3, w_lo);
  assign w_mis_st   = w_store && misaligned(w_f3, w_lo);
  assign misalign_o = ((r_state_q == RESP) && r_mis_q) || w_mis_st;
`else
  assign w_mis_ld = 1'b0;
  assign w_mis_st = 1'b0;
`endif

  assign w_be = (w_store && !w_mis_st) ? byte_en(w_f3, w_lo) : 4'b0000;

  always_comb begin
    w_wdata = wdata_i[31:0];
    case (w_f3)
      F3_B:    w_wdata = {4{wdata_i[7:0]}};
      F3_H:    w_wdata = {2{wdata_i[15:0]}};
      default: w_wdata = wdata_i[31:0];
    endcase
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .i_clk   (clk),
    .i_idx   (addr_i[IDX_W+1:2]),
    .i_we    (w_be),
    .i_wdata (w_wdata),
    .i_re    (w_accept),
    .o_rdata (w_rd)
  );

  assign w_count_inc = r_count_q + CNT_W'(1);

  always_comb begin
    r_state_d = r_state_q;
    r_count_d = r_count_q;
    unique case (r_state_q)
      IDLE: begin
        if (w_accept) begin
          r_count_d = '0;
          r_state_d = (LOAD_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        r_count_d = w_count_inc;
        if (w_count_inc == CNT_W'(LOAD_LATENCY - 1)) r_state_d = RESP;
      end
      RESP:    r_state_d = IDLE;
      default: r_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= IDLE;
      r_count_q <= '0;
      r_lo_q    <= 2'b00;
      r_f3_q    <= F3_W;
      r_mis_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_count_q <= r_count_d;
      if (w_accept) begin
        r_lo_q  <= w_lo;
        r_f3_q  <= w_f3;
        r_mis_q <= w_mis_ld;
      end
    end
  end

  assign w_byte = w_rd[{r_lo_q, 3'b000} +: 8];
  assign w_half = r_lo_q[1] ? w_rd[31:16] : w_rd[15:0];

  always_comb begin
    w_ext = 32'h0;
    case (r_f3_q)
      F3_B:    w_ext = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_ext = {24'h0, w_byte};
      F3_H:    w_ext = {{16{w_half[15]}}, w_half};
      F3_HU:   w_ext = {16'h0, w_half};
      F3_W:    w_ext = w_rd;
      default: w_ext = 32'h0;
    endcase
  end

  // Output is driven only from flops, forced to zero outside the response cycle.
  assign rdata_o  = ((r_state_q == RESP) && !r_mis_q) ? w_ext : '0;
  assign DM_valid = (r_state_q == RESP);
  assign busy_o   = (r_state_q != IDLE);

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit at LOAD_LATENCY=2.
// Covers the DMEM_MISALIGN_EN build when that macro is defined.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Load = 1'b0;
  logic        Store = 1'b0;
  logic [2:0]  fun3 = 3'b010;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] rdata_o;
  logic        DM_valid;
  logic        busy_o;
`ifdef DMEM_MISALIGN_EN
  logic        misalign_o;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  data_mem_unit #(
    .LOAD_LATENCY (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Load     (Load),
    .Store    (Store),
    .fun3     (fun3),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .DM_valid (DM_valid),
    .busy_o   (busy_o)
`ifdef DMEM_MISALIGN_EN
    ,
    .misalign_o (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && Store && busy_o) begin
      bad++;
      $display("FAIL store_while_busy: Store=1 busy_o=1, required never both");
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    Load = 1'b0; Store = 1'b1; fun3 = f3; addr_i = a; wdata_i = d;
    tick();
    Store = 1'b0;
  endtask

  // Leaves the bench one cycle after the response, with Load low.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, output logic [31:0] d,
                         output int lat, output logic busy_mid, output logic mis,
                         output logic after_valid, output int t_valid);
    Load = 1'b1; Store = 1'b0; fun3 = f3; addr_i = a;
    tick();
    lat = 1;
    busy_mid = busy_o;
    while (DM_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    d = rdata_o;
    t_valid = cyc;
`ifdef DMEM_MISALIGN_EN
    mis = misalign_o;
`else
    mis = 1'b0;
`endif
    Load = 1'b0;
    tick();
    after_valid = DM_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (DM_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", DM_valid); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
`ifdef DMEM_MISALIGN_EN
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL reset_mis: got %b want 0", misalign_o); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_word();
    logic [31:0] d; int lat; logic bm, ms, av; int tv;
    do_store(3'b010, 32'h10, 32'hDEADBEEF);
    do_load(3'b010, 32'h10, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", d); end
    total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
    total++; if (bm !== 1'b1) begin bad++; $display("FAIL lw_busy: got %b want 1", bm); end
    total++; if (av !== 1'b0) begin bad++; $display("FAIL lw_single_pulse: got %b want 0", av); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL lw_idle_after: got %b want 0", busy_o); end
  endtask

  task automatic test_extend();
    logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] ad [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] ex [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hFFFFFFEF};
    logic [31:0] d; int lat; logic bm, ms, av; int tv;
    for (int i = 0; i < 5; i++) begin
      do_load(f3[i], ad[i], d, lat, bm, ms, av, tv);
      total++;
      if (d !== ex[i]) begin
        bad++; $display("FAIL extend_%0d: got %h want %h", i, d, ex[i]);
      end
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] d; int lat; logic bm, ms, av; int tv;
    do_store(3'b000, 32'h11, 32'hAABBCC55);
    do_load(3'b010, 32'h10, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_merge: got %h want dead55ef", d); end
    do_store(3'b001, 32'h12, 32'hFFFF1234);
    do_load(3'b010, 32'h10, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'h123455EF) begin bad++; $display("FAIL sh_merge: got %h want 123455ef", d); end
  endtask

  task automatic test_bad_fun3();
    logic [31:0] d; int lat; logic bm, ms, av; int tv;
    do_store(3'b011, 32'h10, 32'h00000000);
    do_load(3'b010, 32'h10, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'h123455EF) begin bad++; $display("FAIL bad_store: got %h want 123455ef", d); end
    do_load(3'b011, 32'h10, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL bad_load: got %h want 0", d); end
    total++; if (lat !== 2) begin bad++; $display("FAIL bad_load_lat: got %0d want 2", lat); end
  endtask

  task automatic test_store_priority();
    logic [31:0] d; int lat; logic bm, ms, av; int tv;
    Load = 1'b1; Store = 1'b1; fun3 = 3'b010; addr_i = 32'h30; wdata_i = 32'h01020304;
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL both_busy: got %b want 0", busy_o); end
    Store = 1'b0;
    do_load(3'b010, 32'h30, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'h01020304) begin bad++; $display("FAIL both_data: got %h want 01020304", d); end
    total++; if (lat !== 2) begin bad++; $display("FAIL both_lat: got %0d want 2", lat); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; int lat; logic bm, ms, av; int tv;
    do_store(3'b010, 32'h20, 32'hCAFEF00D);
    do_load(3'b010, 32'h1020, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap: got %h want cafef00d", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2; int lat; logic bm, ms, av; int t1, t2;
    do_store(3'b010, 32'h14, 32'h0BADF00D);
    do_load(3'b010, 32'h10, d1, lat, bm, ms, av, t1);
    do_load(3'b010, 32'h14, d2, lat, bm, ms, av, t2);
    total++; if (t2 - t1 !== 3) begin bad++; $display("FAIL b2b_gap: got %0d want 3", t2 - t1); end
    total++; if (d1 !== 32'h123455EF) begin bad++; $display("FAIL b2b_d1: got %h want 123455ef", d1); end
    total++; if (d2 !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_d2: got %h want 0badf00d", d2); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; int lat; logic bm, ms, av; int tv; logic seen;
    Load = 1'b1; Store = 1'b0; fun3 = 3'b010; addr_i = 32'h10;
    tick();
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rstmid_busy_pre: got %b want 1", busy_o); end
    rst = 1'b1; Load = 1'b0;
    tick();
    total++; if (DM_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", DM_valid); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (DM_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_late_valid: got %b want 0", seen); end
    do_load(3'b010, 32'h10, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'h123455EF) begin bad++; $display("FAIL rstmid_mem: got %h want 123455ef", d); end
  endtask

  task automatic test_misalign();
    logic [31:0] d; int lat; logic bm, ms, av; int tv;
`ifdef DMEM_MISALIGN_EN
    do_load(3'b010, 32'h11, d, lat, bm, ms, av, tv);
    total++; if (ms !== 1'b1) begin bad++; $display("FAIL mis_lw_flag: got %b want 1", ms); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mis_lw_data: got %h want 0", d); end
    total++; if (lat !== 2) begin bad++; $display("FAIL mis_lw_lat: got %0d want 2", lat); end
    Store = 1'b1; fun3 = 3'b001; addr_i = 32'h13; wdata_i = 32'h0000AAAA;
    #1;
    total++; if (misalign_o !== 1'b1) begin bad++; $display("FAIL mis_sh_flag: got %b want 1", misalign_o); end
    tick();
    Store = 1'b0;
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_sh_pulse: got %b want 0", misalign_o); end
    do_load(3'b010, 32'h10, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'h123455EF) begin bad++; $display("FAIL mis_sh_mem: got %h want 123455ef", d); end
    total++; if (ms !== 1'b0) begin bad++; $display("FAIL mis_aligned_flag: got %b want 0", ms); end
`else
    do_load(3'b010, 32'h11, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'h123455EF) begin bad++; $display("FAIL align_lw: got %h want 123455ef", d); end
    do_load(3'b001, 32'h13, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'h00001234) begin bad++; $display("FAIL align_lh: got %h want 00001234", d); end
    do_load(3'b101, 32'h11, d, lat, bm, ms, av, tv);
    total++; if (d !== 32'h000055EF) begin bad++; $display("FAIL align_lhu: got %h want 000055ef", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_partial_store();
    test_bad_fun3();
    test_store_priority();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
